instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_skid.sv | 26 ++
 rtl/instr_fetch.sv | 135 +++++++++++++
 tb/tb_instr_fetch.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, skid record layout, default bubble word.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam int          SKID_W           = 48;

  // Skid record layout: instruction word in the upper 32 bits, its address below.
  function automatic logic [SKID_W-1:0] skid_pack(input logic [31:0] word,
                                                  input logic [15:0] addr);
    return {word, addr};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register holding an instruction word and its address while decode stalls.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic              flush,
  input  logic [SKID_W-1:0] din,
  output logic              valid,
  output logic [SKID_W-1:0] dout
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (flush) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues sequential reads, absorbs decode stalls in a skid entry,
// and drains an in-flight read after a redirect so stale data never reaches decode.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stall,
  input  logic        jmp,
  input  logic [15:0] jmp_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] IR2,
  output logic [15:0] PC2,
  output logic        valid2,
  output logic [1:0]  fsm_state
);

  // Memory handshake: a read is in flight whenever imem_req=1; it completes in the cycle
  // imem_ack=1, and imem_addr must not change until then.

  fetch_state_t state, state_next;
  logic [15:0]  pc, pc_next;
  logic [15:0]  drain_addr, drain_next;
  logic [31:0]  ir2_next;
  logic [15:0]  pc2_next;
  logic         valid2_next;
  logic         skid_load, skid_flush, skid_valid;
  logic [SKID_W-1:0] skid_dout;

  fetch_skid u_skid (
    .clk   (clk),
    .clr   (clr),
    .load  (skid_load),
    .flush (skid_flush),
    .din   (skid_pack(imem_data, pc)),
    .valid (skid_valid),
    .dout  (skid_dout)
  );

  assign fsm_state = state;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      drain_addr <= 16'h0000;
      IR2        <= NOP_WORD;
      PC2        <= 16'h0000;
      valid2     <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      drain_addr <= drain_next;
      IR2        <= ir2_next;
      PC2        <= pc2_next;
      valid2     <= valid2_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    drain_next  = drain_addr;
    ir2_next    = IR2;
    pc2_next    = PC2;
    valid2_next = valid2;
    skid_load   = 1'b0;
    skid_flush  = 1'b0;
    imem_req    = 1'b1;
    imem_addr   = pc;

    case (state)
      FETCH: begin
        if (stall) begin
          // Decode is frozen, so a returning word parks in the skid entry.
          if (imem_ack) begin
            skid_load  = 1'b1;
            pc_next    = pc + 16'd1;
            state_next = HOLD;
          end
        end else if (jmp) begin
          pc_next     = jmp_target;
          ir2_next    = NOP_WORD;
          valid2_next = 1'b0;
          skid_flush  = 1'b1;
          if (!imem_ack) begin
            drain_next = pc;
            state_next = DRAIN;
          end
        end else if (imem_ack) begin
          ir2_next    = imem_data;
          pc2_next    = pc;
          valid2_next = 1'b1;
          pc_next     = pc + 16'd1;
        end else begin
          ir2_next    = NOP_WORD;
          valid2_next = 1'b0;
        end
      end

      HOLD: begin
        imem_req = 1'b0;
        if (!stall) begin
          skid_flush = 1'b1;
          state_next = FETCH;
          if (jmp) begin
            pc_next     = jmp_target;
            ir2_next    = NOP_WORD;
            valid2_next = 1'b0;
          end else begin
            ir2_next    = skid_dout[47:16];
            pc2_next    = skid_dout[15:0];
            valid2_next = skid_valid;
          end
        end
      end

      DRAIN: begin
        // Keep presenting the abandoned address until memory retires it; its data is dropped.
        imem_addr = drain_addr;
        if (jmp && !stall) pc_next = jmp_target;
        if (imem_ack) state_next = FETCH;
      end

      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written redirect/reset sequences,
// and random traffic checked against a transaction-level reference model.
module tb_instr_fetch;

  logic        clk;
  logic        clr;
  logic        stall;
  logic        jmp;
  logic [15:0] jmp_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] IR2;
  logic [15:0] PC2;
  logic        valid2;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  instr_fetch dut (
    .clk        (clk),
    .clr        (clr),
    .stall      (stall),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .IR2        (IR2),
    .PC2        (PC2),
    .valid2     (valid2),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: pending skid words and abandoned addresses kept as queues
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  logic [15:0] m_pc2;
  logic        m_v;
  logic [47:0] m_skid_q[$];
  logic [15:0] m_drain_q[$];

  task automatic model_reset();
    m_pc  = 16'h0000;
    m_ir  = 32'h0;
    m_pc2 = 16'h0000;
    m_v   = 1'b0;
    m_skid_q.delete();
    m_drain_q.delete();
  endtask

  function automatic logic model_req();
    if (m_drain_q.size() != 0) return 1'b1;
    if (m_skid_q.size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] model_addr();
    if (m_drain_q.size() != 0) return m_drain_q[0];
    return m_pc;
  endfunction

  task automatic model_step(input logic s, input logic j, input logic [15:0] t,
                            input logic a, input logic [31:0] d);
    logic [47:0] e;
    if (m_drain_q.size() != 0) begin
      if (j && !s) m_pc = t;
      if (a) m_drain_q.delete();
    end else if (m_skid_q.size() != 0) begin
      if (!s) begin
        e = m_skid_q.pop_front();
        if (j) begin
          m_pc = t; m_ir = 32'h0; m_v = 1'b0;
        end else begin
          m_ir = e[47:16]; m_pc2 = e[15:0]; m_v = 1'b1;
        end
      end
    end else if (s) begin
      if (a) begin
        m_skid_q.push_back({d, m_pc});
        m_pc = m_pc + 16'd1;
      end
    end else if (j) begin
      if (!a) m_drain_q.push_back(m_pc);
      m_pc = t; m_ir = 32'h0; m_v = 1'b0;
    end else if (a) begin
      m_ir = d; m_pc2 = m_pc; m_v = 1'b1; m_pc = m_pc + 16'd1;
    end else begin
      m_ir = 32'h0; m_v = 1'b0;
    end
  endtask

  // scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic        smp_req;
  logic [15:0] smp_addr;

  // driver: one clock of stimulus, compared against the model before and after the edge
  task automatic step(input logic s, input logic j, input logic [15:0] t,
                      input logic a, input logic [31:0] d);
    logic        er;
    logic [15:0] ea;
    @(negedge clk);
    stall = s; jmp = j; jmp_target = t; imem_ack = a; imem_data = d;
    #1;
    er = model_req();
    ea = model_addr();
    smp_req  = imem_req;
    smp_addr = imem_addr;
    chk("model_req", {31'b0, imem_req}, {31'b0, er});
    if (er) chk("model_addr", {16'b0, imem_addr}, {16'b0, ea});
    model_step(s, j, t, a, d);
    @(posedge clk);
    #1;
    chk("model_ir2", IR2, m_ir);
    chk("model_pc2", {16'b0, PC2}, {16'b0, m_pc2});
    chk("model_valid2", {31'b0, valid2}, {31'b0, m_v});
  endtask

  typedef struct {
    logic        s;
    logic        j;
    logic [15:0] t;
    logic        a;
    logic [31:0] d;
    logic        e_req;
    logic [15:0] e_addr;
    logic [31:0] e_ir;
    logic [15:0] e_pc2;
    logic        e_v;
  } vec_t;

  vec_t tbl[16];

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ir2"},    IR2, 32'h0);
    chk({tag, "_pc2"},    {16'b0, PC2}, 32'h0);
    chk({tag, "_valid2"}, {31'b0, valid2}, 32'h0);
    chk({tag, "_req"},    {31'b0, imem_req}, 32'h1);
    chk({tag, "_addr"},   {16'b0, imem_addr}, 32'h0);
  endtask

  initial begin
    logic        rs, rj, ra;
    logic [15:0] rt;
    clr = 1'b0; stall = 1'b0; jmp = 1'b0; jmp_target = 16'h0;
    imem_ack = 1'b0; imem_data = 32'h0;
    model_reset();

    // sequential run, stall/skid, bubble, jump-with-ack, PC wrap
    tbl[0]  = '{0, 0, 16'h0000, 1, 32'hA000_0001, 1, 16'h0000, 32'hA000_0001, 16'h0000, 1};
    tbl[1]  = '{0, 0, 16'h0000, 1, 32'hA000_0002, 1, 16'h0001, 32'hA000_0002, 16'h0001, 1};
    tbl[2]  = '{0, 0, 16'h0000, 1, 32'hA000_0003, 1, 16'h0002, 32'hA000_0003, 16'h0002, 1};
    tbl[3]  = '{0, 0, 16'h0000, 1, 32'hA000_0004, 1, 16'h0003, 32'hA000_0004, 16'h0003, 1};
    tbl[4]  = '{0, 0, 16'h0000, 1, 32'hA000_0005, 1, 16'h0004, 32'hA000_0005, 16'h0004, 1};
    tbl[5]  = '{1, 0, 16'h0000, 1, 32'hC0DE_0005, 1, 16'h0005, 32'hA000_0005, 16'h0004, 1};
    tbl[6]  = '{1, 1, 16'h0099, 0, 32'h0000_0000, 0, 16'h0000, 32'hA000_0005, 16'h0004, 1};
    tbl[7]  = '{1, 0, 16'h0000, 0, 32'h0000_0000, 0, 16'h0000, 32'hA000_0005, 16'h0004, 1};
    tbl[8]  = '{0, 0, 16'h0000, 0, 32'h0000_0000, 0, 16'h0000, 32'hC0DE_0005, 16'h0005, 1};
    tbl[9]  = '{0, 0, 16'h0000, 0, 32'h0000_0000, 1, 16'h0006, 32'h0000_0000, 16'h0005, 0};
    tbl[10] = '{0, 0, 16'h0000, 1, 32'hD000_0006, 1, 16'h0006, 32'hD000_0006, 16'h0006, 1};
    tbl[11] = '{0, 1, 16'h0040, 1, 32'hEEEE_0007, 1, 16'h0007, 32'h0000_0000, 16'h0006, 0};
    tbl[12] = '{0, 0, 16'h0000, 1, 32'h4040_4040, 1, 16'h0040, 32'h4040_4040, 16'h0040, 1};
    tbl[13] = '{0, 1, 16'hFFFF, 1, 32'hBAD0_0041, 1, 16'h0041, 32'h0000_0000, 16'h0040, 0};
    tbl[14] = '{0, 0, 16'h0000, 1, 32'hFFFF_0000, 1, 16'hFFFF, 32'hFFFF_0000, 16'hFFFF, 1};
    tbl[15] = '{0, 0, 16'h0000, 1, 32'h1234_5678, 1, 16'h0000, 32'h1234_5678, 16'h0000, 1};

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    clr = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].s, tbl[i].j, tbl[i].t, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_req", i), {31'b0, smp_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("vec%0d_addr", i), {16'b0, smp_addr}, {16'b0, tbl[i].e_addr});
      chk($sformatf("vec%0d_ir2", i), IR2, tbl[i].e_ir);
      chk($sformatf("vec%0d_pc2", i), {16'b0, PC2}, {16'b0, tbl[i].e_pc2});
      chk($sformatf("vec%0d_valid2", i), {31'b0, valid2}, {31'b0, tbl[i].e_v});
    end

    // redirect while a 3-cycle read is outstanding at 0x0010
    step(0, 1, 16'h0010, 1, 32'hBAD0_0001);
    step(0, 1, 16'h0040, 0, 32'h0);
    chk("drain_issue_addr", {16'b0, smp_addr}, 32'h0010);
    step(0, 0, 16'h0000, 0, 32'h0);
    chk("drain_hold_addr1", {16'b0, smp_addr}, 32'h0010);
    chk("drain_valid2_a", {31'b0, valid2}, 32'h0);
    step(0, 0, 16'h0000, 1, 32'hDEAD_0010);
    chk("drain_hold_addr2", {16'b0, smp_addr}, 32'h0010);
    chk("drain_discard_v", {31'b0, valid2}, 32'h0);
    chk("drain_discard_ir", IR2, 32'h0);
    step(0, 0, 16'h0000, 1, 32'h5555_0040);
    chk("drain_target_addr", {16'b0, smp_addr}, 32'h0040);
    chk("drain_target_ir", IR2, 32'h5555_0040);

    // asynchronous reset in the middle of a drain
    step(0, 1, 16'h0080, 0, 32'h0);
    @(negedge clk);
    stall = 1'b0; jmp = 1'b0; imem_ack = 1'b0;
    #2 clr = 1'b0;
    #1;
    check_reset_outputs("clr_mid_drain");
    model_reset();
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("restart_req", {31'b0, imem_req}, 32'h1);
    chk("restart_addr", {16'b0, imem_addr}, 32'h0);
    step(0, 0, 16'h0000, 1, 32'hCAFE_0000);
    chk("restart_ir2", IR2, 32'hCAFE_0000);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rs = ($urandom_range(0, 3) == 0);
      rj = ($urandom_range(0, 6) == 0);
      rt = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                       : 16'($urandom_range(0, 65535));
      ra = model_req() ? 1'($urandom_range(0, 1)) : 1'b0;
      step(rs, rj, rt, ra, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
